// File: rtl/fixed_to_float.sv
// Multi-cycle signed fixed-point to IEEE-754 single converter for the Nios II
// custom-instruction port: one normalising shift per cycle, then round-to-nearest-even.
module fixed_to_float #(
    parameter int FRAC_BITS = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        FIN
    } state_t;

    // Biased exponent of a magnitude whose leading one already sits in bit 31.
    localparam logic [7:0] EXP_BASE = 8'(127 + 31 - FRAC_BITS);

    state_t      state;
    state_t      state_next;
    logic        sign;
    logic        sign_next;
    logic [31:0] mag;
    logic [31:0] mag_next;
    logic [4:0]  cnt;
    logic [4:0]  cnt_next;
    logic        done_next;
    logic [31:0] result_next;

    logic [31:0] abs_a;
    logic [7:0]  exp_raw;
    logic        round_up;
    logic [23:0] man_rnd;
    logic [7:0]  exp_fin;
    logic [22:0] man_fin;

    // Two's complement negate; 0x80000000 maps onto itself, which is the correct unsigned magnitude.
    assign abs_a = dataa[31] ? (~dataa + 32'd1) : dataa;

    // Bits below the 23 kept mantissa bits: mag[7] is guard, mag[6:0] fold into sticky.
    assign exp_raw  = EXP_BASE - {3'd0, cnt};
    assign round_up = mag[7] & ((|mag[6:0]) | mag[8]);
    assign man_rnd  = {1'b0, mag[30:8]} + {23'd0, round_up};
    assign exp_fin  = exp_raw + {7'd0, man_rnd[23]};
    assign man_fin  = man_rnd[22:0];

    always_comb begin
        state_next  = state;
        sign_next   = sign;
        mag_next    = mag;
        cnt_next    = cnt;
        done_next   = 1'b0;
        result_next = result;

        case (state)
            IDLE: begin
                if (start) begin
                    sign_next = dataa[31];
                    mag_next  = abs_a;
                    cnt_next  = 5'd0;
                    if (dataa == 32'd0) begin
                        result_next = 32'h0000_0000;
                        done_next   = 1'b1;
                    end else begin
                        state_next = NORM;
                    end
                end
            end
            NORM: begin
                if (!mag[31]) begin
                    mag_next = mag << 1;
                    cnt_next = cnt + 5'd1;
                end else begin
                    state_next = ROUND;
                end
            end
            ROUND: begin
                result_next = {sign, exp_fin, man_fin};
                done_next   = 1'b1;
                state_next  = FIN;
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Everything, including the done pulse, freezes while clk_en is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            sign   <= 1'b0;
            mag    <= 32'd0;
            cnt    <= 5'd0;
            done   <= 1'b0;
            result <= 32'd0;
        end else if (clk_en) begin
            state  <= state_next;
            sign   <= sign_next;
            mag    <= mag_next;
            cnt    <= cnt_next;
            done   <= done_next;
            result <= result_next;
        end
    end

endmodule

// File: doc/fixed_to_float.md
Name: fixed_to_float

Overview:
- Multi-cycle converter from signed fixed-point (CORDIC output format) to IEEE-754 single-precision float.
- It is the reverse of the float-to-fixed path that feeds the cosine core. It lets cosine results return to the Nios II as float.
- Uses the Nios II multi-cycle custom-instruction handshake (clk_en/start/done).
- Normalisation is iterative, one left shift per cycle. Rounding is round-to-nearest-even.

Parameters:
- FRAC_BITS, 30, number of fraction bits in dataa (two's complement, 32 bits total); legal range 0..31.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- clk_en  input  1  global enable; when 0 every register holds its value.
- start  input  1  single-cycle request; sampled only in IDLE with clk_en=1.
- dataa  input  32  signed fixed-point operand, value = dataa / 2^FRAC_BITS.
- done  output  1  one-cycle pulse when result is valid.
- result  output  32  IEEE-754 single; holds its value until the next done.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, done=0, result=32'h0, internal magnitude/count/sign cleared.
  - Reset mid-conversion aborts the conversion; no done is produced.
- States: IDLE, NORM, ROUND, FIN.
- IDLE: on edge with start=1, clk_en=1:
  - sign <= dataa[31].
  - mag <= |dataa| as 32-bit unsigned (0x80000000 gives mag 0x80000000).
  - cnt <= 0.
  - If dataa==0: result <= 0x00000000, done <= 1, stay IDLE (latency 1).
  - Otherwise go to NORM.
- NORM:
  - If mag[31]=0: mag <= mag<<1, cnt <= cnt+1.
  - Else go to ROUND.
  - cnt is 5 bits; at most 31 shifts.
- ROUND:
  - exp = 127 + (31-FRAC_BITS) - cnt, 8 bits. Always normal: no denormals, no overflow for legal FRAC_BITS.
  - man = mag[30:8], guard g = mag[7], sticky s = |mag[6:0].
  - Round up iff g & (s | man[0]).
  - Carry out of man: man=0, exp+1.
  - result <= {sign, exp, man}, done <= 1, go to FIN.
- FIN: done <= 0, go to IDLE.
- done is high for exactly one clk_en-qualified cycle.
- Latency for nonzero input: done asserts L = lz+2 enabled edges after the start edge, where lz is the leading-zero count of the magnitude. Minimum 2 (|dataa| ≥ 2^31); maximum 33.
- start asserted outside IDLE is ignored; no queueing.
- clk_en=0 freezes the FSM, mag, cnt, done and result, including mid-NORM. done remains 1 if frozen in the pulse cycle.
- result changes only on a done edge.
- No valid input produces NaN or Inf; -0 is never generated.

Test Plan:
- Reset asserted asynchronously mid-NORM (start with 0x00000001, reset after 5 cycles) -> done stays 0, result=0x00000000, next start 0x40000000 converts normally.
- Basic values, FRAC_BITS=30, with done latency checked each time:
  - 0x40000000 -> 0x3F800000, 3 cycles.
  - 0xC0000000 -> 0xBF800000.
  - 0x20000000 -> 0x3F000000.
  - 0x00000001 -> 0x30800000, 33 cycles.
  - 0x80000000 -> 0xC0000000, 2 cycles.
- Zero and back-to-back: 0x00000000 -> result 0x00000000 with done after 1 cycle. Immediately restart with 0x40000000 -> 0x3F800000. A start pulsed during busy is ignored.
- Rounding:
  - 0x40000040 -> 0x3F800000 (tie, even, no round).
  - 0x400000C0 -> 0x3F800002 (tie, round up).
  - 0x7FFFFFFF -> 0x40000000 (mantissa carry into exponent).
- clk_en: hold clk_en=0 for 4 cycles during NORM of 0x00010000 -> latency extends by exactly 4, result 0x38800000.
- Random: 1000 random dataa compared against a real-valued reference model (dataa/2^30 cast to single, RNE) -> bit-exact match, done count equals start count.
